// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg -- shared types and constants for the maze robot datapath.
//   accum_state_e : state encoding of the IR error accumulator FSM
//   IR_W_DEF      : default width of one unsigned IR reading
//   acc_width()   : accumulator width that cannot overflow for a given
//                   reading width and number of sensor pairs
// ---------------------------------------------------------------------------
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } accum_state_e;

  localparam int unsigned IR_W_DEF = 12;

  // |sum| <= (2^ir_w - 1) * (2^npair - 1) < 2^(ir_w+npair), plus one sign bit.
  function automatic int unsigned acc_width(input int unsigned ir_w,
                                            input int unsigned npair);
    return ir_w + npair + 1;
  endfunction

endpackage

// File: rtl/err_accum_n_if.sv
// ---------------------------------------------------------------------------
// err_accum_n_if -- signal bundle between the IR front end / cmd_proc and
// the error accumulator.
//   master : drives IR_R, IR_L, IR_vld, line_present, err_opn_lp, clr_ovr;
//            observes error, err_vld, busy, overrun
//   slave  : the accumulator side (opposite directions)
// ---------------------------------------------------------------------------
interface err_accum_n_if
  import maze_pkg::*;
#(
  parameter int unsigned NPAIR = 4,
  parameter int unsigned IR_W  = IR_W_DEF,
  parameter int unsigned OUT_W = 16
);

  logic        [NPAIR*IR_W-1:0] IR_R;
  logic        [NPAIR*IR_W-1:0] IR_L;
  logic                         IR_vld;
  logic                         line_present;
  logic        [OUT_W-1:0]      err_opn_lp;
  logic                         clr_ovr;
  logic signed [OUT_W-1:0]      error;
  logic                         err_vld;
  logic                         busy;
  logic                         overrun;

  modport master (
    output IR_R, IR_L, IR_vld, line_present, err_opn_lp, clr_ovr,
    input  error, err_vld, busy, overrun
  );

  modport slave (
    input  IR_R, IR_L, IR_vld, line_present, err_opn_lp, clr_ovr,
    output error, err_vld, busy, overrun
  );

endinterface

// File: rtl/err_sat.sv
// ---------------------------------------------------------------------------
// err_sat -- purely combinational signed saturation from IN_W to OUT_W bits.
//   din_i  : signed IN_W input
//   dout_o : signed OUT_W result, clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
// When IN_W <= OUT_W the value always fits and is just sign-extended.
// ---------------------------------------------------------------------------
module err_sat #(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  generate
    if (IN_W <= OUT_W) begin : g_ext
      assign dout_o = OUT_W'(din_i);
    end else begin : g_clip
      localparam logic signed [IN_W-1:0] MAXV =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IN_W-1:0] MINV =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

      always_comb begin
        if (din_i > MAXV) begin
          dout_o = MAXV[OUT_W-1:0];
        end else if (din_i < MINV) begin
          dout_o = MINV[OUT_W-1:0];
        end else begin
          dout_o = din_i[OUT_W-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/err_accum_n.sv
// ---------------------------------------------------------------------------
// err_accum_n -- weighted IR line-position error accumulator.
// On an accepted IR_vld the NPAIR right/left readings are snapshotted, then
// one pair per cycle is folded into the accumulator as (R[k]-L[k]) << k
// using a single subtract/add datapath. The result (saturated to OUT_W) or
// the open-loop term err_opn_lp, chosen by line_present in the output cycle,
// is presented on error with a one-cycle err_vld strobe.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus.IR_R / IR_L   : flattened readings, pair k at [k*IR_W +: IR_W]
//   bus.IR_vld        : strobe, readings valid this cycle
//   bus.line_present  : 1 -> sensor error, 0 -> err_opn_lp
//   bus.err_opn_lp    : open-loop steering term
//   bus.clr_ovr       : clears overrun
//   bus.error         : signed error, held between strobes
//   bus.err_vld       : one-cycle strobe, error updated
//   bus.busy          : computation in flight
//   bus.overrun       : sticky, an IR_vld was dropped while busy
// Latency IR_vld -> err_vld is NPAIR+1 cycles; one result per NPAIR+2.
// ---------------------------------------------------------------------------
module err_accum_n
  import maze_pkg::*;
#(
  parameter int unsigned NPAIR = 4,
  parameter int unsigned IR_W  = IR_W_DEF,
  parameter int unsigned OUT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  err_accum_n_if.slave bus
);

  localparam int unsigned ACC_W = acc_width(IR_W, NPAIR);
  localparam int unsigned IDX_W = $clog2(NPAIR);

  accum_state_e                state_q, state_d;
  logic        [NPAIR*IR_W-1:0] r_q, r_d;
  logic        [NPAIR*IR_W-1:0] l_q, l_d;
  logic        [IDX_W-1:0]      idx_q, idx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [OUT_W-1:0]      error_q, error_d;
  logic                         overrun_q, overrun_d;

  logic        [IR_W-1:0]       r_sel, l_sel;
  logic signed [IR_W:0]         diff;
  logic signed [ACC_W-1:0]      diff_ext;
  logic signed [ACC_W-1:0]      term;
  logic signed [OUT_W-1:0]      sat_val;
  logic signed [OUT_W-1:0]      result;
  logic                         busy;
  logic                         out_cyc;

  // Pair select from the snapshot registers for the current index.
  always_comb begin
    r_sel = '0;
    l_sel = '0;
    for (int unsigned k = 0; k < NPAIR; k++) begin
      if (idx_q == IDX_W'(k)) begin
        r_sel = r_q[k*IR_W +: IR_W];
        l_sel = l_q[k*IR_W +: IR_W];
      end
    end
  end

  // Shared datapath: one subtract, sign-extend, weight by 2^idx.
  assign diff     = $signed({1'b0, r_sel}) - $signed({1'b0, l_sel});
  assign diff_ext = {{NPAIR{diff[IR_W]}}, diff};
  assign term     = diff_ext << idx_q;

  err_sat #(
    .IN_W (ACC_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .din_i (acc_q),
    .dout_o(sat_val)
  );

  // line_present is looked at only in the OUT cycle.
  assign result = bus.line_present ? sat_val : $signed(bus.err_opn_lp);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    l_d     = l_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    error_d = error_q;
    busy    = 1'b0;
    out_cyc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.IR_vld) begin
          r_d     = bus.IR_R;
          l_d     = bus.IR_L;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy  = 1'b1;
        acc_d = acc_q + term;
        if (idx_q == IDX_W'(NPAIR-1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        busy    = 1'b1;
        out_cyc = 1'b1;
        error_d = result;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A dropped strobe beats a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.IR_vld && busy) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      l_q       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      error_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      l_q       <= l_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  // The new value is visible in the strobe cycle itself and registered for
  // holding afterwards.
  assign bus.error   = out_cyc ? result : error_q;
  assign bus.err_vld = out_cyc;
  assign bus.busy    = busy;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_err_accum_n.sv
module tb_err_accum_n;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  err_accum_n_if #(.NPAIR(4), .IR_W(12), .OUT_W(16)) b4 ();
  err_accum_n_if #(.NPAIR(6), .IR_W(12), .OUT_W(16)) b6 ();

  err_accum_n #(.NPAIR(4), .IR_W(12), .OUT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );
  err_accum_n #(.NPAIR(6), .IR_W(12), .OUT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6)
  );

  task automatic fill4(input logic [11:0] r, input logic [11:0] l);
    for (int k = 0; k < 4; k++) begin
      b4.IR_R[k*12 +: 12] = r;
      b4.IR_L[k*12 +: 12] = l;
    end
  endtask

  task automatic fill6(input logic [11:0] r, input logic [11:0] l);
    for (int k = 0; k < 6; k++) begin
      b6.IR_R[k*12 +: 12] = r;
      b6.IR_L[k*12 +: 12] = l;
    end
  endtask

  // Issues IR_vld in cycle 0 and observes cycles 1..12. An optional second
  // strobe at extra_at, optional line_present inversion at lp_flip_at.
  task automatic run(input bit six, input int extra_at, input int lp_flip_at,
                     output int fc, output int n, output logic [15:0] e,
                     output logic [15:0] bm);
    fc = -1;
    n  = 0;
    e  = 16'hxxxx;
    bm = '0;
    @(posedge clk); #1;
    if (six) b6.IR_vld = 1'b1; else b4.IR_vld = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      b4.IR_vld = (!six && c == extra_at);
      b6.IR_vld = (six && c == extra_at);
      if (c == lp_flip_at) begin
        if (six) b6.line_present = ~b6.line_present;
        else     b4.line_present = ~b4.line_present;
      end
      @(negedge clk);
      bm[c] = six ? b6.busy : b4.busy;
      if (six ? b6.err_vld : b4.err_vld) begin
        n++;
        if (fc < 0) begin
          fc = c;
          e  = six ? b6.error : b4.error;
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (b4.error !== 16'h0000) $display("FAIL rst_error: got %h want 0000", b4.error); else passed++;
    total++; if (b4.err_vld !== 1'b0) $display("FAIL rst_err_vld: got %b want 0", b4.err_vld); else passed++;
    total++; if (b4.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", b4.busy); else passed++;
    total++; if (b4.overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", b4.overrun); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int fc, n;
    logic [15:0] e, bm;
    fill4(12'h800, 12'h800);
    b4.line_present = 1'b1;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (fc !== 5) $display("FAIL zero_latency: got %0d want 5", fc); else passed++;
    total++; if (n !== 1) $display("FAIL zero_pulses: got %0d want 1", n); else passed++;
    total++; if (e !== 16'h0000) $display("FAIL zero_error: got %h want 0000", e); else passed++;
    total++; if (bm !== 16'h003E) $display("FAIL zero_busy_mask: got %h want 003e", bm); else passed++;
  endtask

  task automatic test_weights();
    int fc, n;
    logic [15:0] e, bm;
    fill4(12'h800, 12'h800);
    b4.IR_R[36 +: 12] = 12'hFFF;
    b4.IR_L[36 +: 12] = 12'h000;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h7FF8) $display("FAIL msb_pos: got %h want 7ff8", e); else passed++;
    total++; if (fc !== 5) $display("FAIL msb_pos_latency: got %0d want 5", fc); else passed++;
    b4.IR_R[36 +: 12] = 12'h000;
    b4.IR_L[36 +: 12] = 12'hFFF;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h8008) $display("FAIL msb_neg: got %h want 8008", e); else passed++;
    // 5*1 - 16*2 + 16*4 + 0*8 = 37
    fill4(12'h800, 12'h800);
    b4.IR_R[0 +: 12]  = 12'h805;
    b4.IR_R[12 +: 12] = 12'h7F0;
    b4.IR_R[24 +: 12] = 12'h810;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h0025) $display("FAIL mixed_weights: got %h want 0025", e); else passed++;
  endtask

  task automatic test_saturation();
    int fc, n;
    logic [15:0] e, bm;
    fill6(12'h800, 12'h800);
    b6.line_present = 1'b1;
    b6.IR_R[60 +: 12] = 12'hFFF;
    b6.IR_L[60 +: 12] = 12'h000;
    run(1'b1, 0, 0, fc, n, e, bm);
    total++; if (fc !== 7) $display("FAIL sat6_latency: got %0d want 7", fc); else passed++;
    total++; if (e !== 16'h7FFF) $display("FAIL sat6_pos: got %h want 7fff", e); else passed++;
    b6.IR_R[60 +: 12] = 12'h000;
    b6.IR_L[60 +: 12] = 12'hFFF;
    run(1'b1, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h8000) $display("FAIL sat6_neg: got %h want 8000", e); else passed++;
    b6.IR_R[60 +: 12] = 12'h801;
    b6.IR_L[60 +: 12] = 12'h800;
    run(1'b1, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h0020) $display("FAIL nosat6: got %h want 0020", e); else passed++;
  endtask

  task automatic test_open_loop();
    int fc, n;
    logic [15:0] e, bm;
    fill4(12'h800, 12'h800);
    b4.IR_R[36 +: 12] = 12'hFFF;
    b4.IR_L[36 +: 12] = 12'h000;
    b4.err_opn_lp = 16'h0140;
    b4.line_present = 1'b0;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (e !== 16'h0140) $display("FAIL open_loop: got %h want 0140", e); else passed++;
    // line_present 0 at IR_vld, 1 by the output cycle
    run(1'b0, 0, 3, fc, n, e, bm);
    total++; if (e !== 16'h7FF8) $display("FAIL lp_late_on: got %h want 7ff8", e); else passed++;
    // line_present 1 at IR_vld, 0 by the output cycle
    run(1'b0, 0, 3, fc, n, e, bm);
    total++; if (e !== 16'h0140) $display("FAIL lp_late_off: got %h want 0140", e); else passed++;
    b4.line_present = 1'b1;
  endtask

  task automatic test_overrun();
    int fc, n;
    logic [15:0] e, bm;
    fill4(12'h800, 12'h800);
    b4.IR_R[36 +: 12] = 12'hFFF;
    b4.IR_L[36 +: 12] = 12'h000;
    run(1'b0, 2, 0, fc, n, e, bm);
    total++; if (fc !== 5) $display("FAIL ovr_latency: got %0d want 5", fc); else passed++;
    total++; if (n !== 1) $display("FAIL ovr_pulses: got %0d want 1", n); else passed++;
    total++; if (e !== 16'h7FF8) $display("FAIL ovr_error: got %h want 7ff8", e); else passed++;
    total++; if (b4.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", b4.overrun); else passed++;
    @(posedge clk); #1 b4.clr_ovr = 1'b1;
    @(posedge clk); #1 b4.clr_ovr = 1'b0;
    @(negedge clk);
    total++; if (b4.overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", b4.overrun); else passed++;
    // dropped strobe and clear in the same cycle
    @(posedge clk); #1 b4.IR_vld = 1'b1;
    @(posedge clk); #1 b4.IR_vld = 1'b0;
    @(posedge clk); #1 begin b4.IR_vld = 1'b1; b4.clr_ovr = 1'b1; end
    @(posedge clk); #1 begin b4.IR_vld = 1'b0; b4.clr_ovr = 1'b0; end
    @(negedge clk);
    total++; if (b4.overrun !== 1'b1) $display("FAIL ovr_clr_collide: got %b want 1", b4.overrun); else passed++;
    repeat (6) @(posedge clk);
    #1 b4.clr_ovr = 1'b1;
    @(posedge clk); #1 b4.clr_ovr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int cyc[2];
    logic [15:0] val[2];
    logic [15:0] held = 16'hxxxx;
    cyc[0] = -1; cyc[1] = -1;
    fill4(12'h800, 12'h800);
    b4.IR_R[36 +: 12] = 12'hFFF;
    b4.IR_L[36 +: 12] = 12'h000;
    @(posedge clk); #1 b4.IR_vld = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      b4.IR_vld = (c == 6);
      if (c == 1) begin
        // change inputs mid-flight; the snapshot must be used
        b4.IR_R[36 +: 12] = 12'h000;
        b4.IR_L[36 +: 12] = 12'hFFF;
      end
      @(negedge clk);
      if (c == 8) held = b4.error;
      if (b4.err_vld) begin
        if (n < 2) begin
          cyc[n] = c;
          val[n] = b4.error;
        end
        n++;
      end
    end
    total++; if (n !== 2) $display("FAIL b2b_pulses: got %0d want 2", n); else passed++;
    total++; if (cyc[0] !== 5 || val[0] !== 16'h7FF8) $display("FAIL b2b_first: got c%0d %h want c5 7ff8", cyc[0], val[0]); else passed++;
    total++; if (cyc[1] !== 11 || val[1] !== 16'h8008) $display("FAIL b2b_second: got c%0d %h want c11 8008", cyc[1], val[1]); else passed++;
    total++; if (held !== 16'h7FF8) $display("FAIL b2b_hold: got %h want 7ff8", held); else passed++;
    total++; if (b4.overrun !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", b4.overrun); else passed++;
  endtask

  task automatic test_reset_midflight();
    int fc, n, pulses;
    logic [15:0] e, bm;
    fill4(12'h800, 12'h800);
    b4.IR_R[36 +: 12] = 12'hFFF;
    b4.IR_L[36 +: 12] = 12'h000;
    @(posedge clk); #1 b4.IR_vld = 1'b1;
    @(posedge clk); #1 b4.IR_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (b4.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", b4.busy); else passed++;
    total++; if (b4.error !== 16'h0000) $display("FAIL midrst_error: got %h want 0000", b4.error); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b4.err_vld) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL midrst_no_vld: got %0d want 0", pulses); else passed++;
    run(1'b0, 0, 0, fc, n, e, bm);
    total++; if (fc !== 5 || e !== 16'h7FF8) $display("FAIL midrst_restart: got c%0d %h want c5 7ff8", fc, e); else passed++;
  endtask

  initial begin
    b4.IR_R = '0; b4.IR_L = '0; b4.IR_vld = 1'b0; b4.line_present = 1'b1;
    b4.err_opn_lp = '0; b4.clr_ovr = 1'b0;
    b6.IR_R = '0; b6.IR_L = '0; b6.IR_vld = 1'b0; b6.line_present = 1'b1;
    b6.err_opn_lp = '0; b6.clr_ovr = 1'b0;
    test_reset();
    test_zero();
    test_weights();
    test_saturation();
    test_open_loop();
    test_overrun();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
